// File: rtl/hc_enc_pipe.sv
// Hamming encoder (check bits at power-of-two positions) feeding a 2-entry output FIFO; macro HC_ENC_ERR_INJ_EN adds one-bit error injection.
// Latency: accepted word is visible after one edge. Backpressure: o_ready = buffer not full, from registered state only.
module hc_enc_pipe #(
  parameter int DATA_WD = 4,
  parameter int CHK_WD  = 3,
  parameter int CNT_WD  = 16
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_valid,
  output logic                       o_ready,
  input  logic [DATA_WD-1:0]         i_data,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic [DATA_WD+CHK_WD-1:0]  o_enc_data,
  output logic [CNT_WD-1:0]          o_acc_cnt
`ifdef HC_ENC_ERR_INJ_EN
  ,
  input  logic                       i_inj_en,
  input  logic [CHK_WD-1:0]          i_inj_pos
`endif
);

  localparam int N = DATA_WD + CHK_WD;

  logic [N-1:0]      code;
  logic [N-1:0]      inj_mask;
  logic [N-1:0]      mem [2];
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        count;
  logic [CNT_WD-1:0] acc_cnt;
  logic              push;
  logic              pop;

  // Data fills non-power-of-two positions first; parity slots are still zero when summed.
  always_comb begin
    int  di;
    logic par;
    code = '0;
    di   = 0;
    par  = 1'b0;
    for (int j = 1; j <= N; j++) begin
      if ((j & (j - 1)) != 0) begin
        code[j-1] = i_data[di];
        di++;
      end
    end
    for (int i = 0; i < CHK_WD; i++) begin
      par = 1'b0;
      for (int j = 1; j <= N; j++) begin
        if (((j >> i) & 1) == 1) par = par ^ code[j-1];
      end
      code[(1 << i) - 1] = par;
    end
  end

`ifdef HC_ENC_ERR_INJ_EN
  // Positions outside 1..N never match, so they leave the word clean.
  always_comb begin
    inj_mask = '0;
    for (int j = 1; j <= N; j++) begin
      if (i_inj_en && (int'(i_inj_pos) == j)) inj_mask[j-1] = 1'b1;
    end
  end
`else
  assign inj_mask = '0;
`endif

  assign o_ready    = (count != 2'd2);
  assign o_valid    = (count != 2'd0);
  assign o_enc_data = mem[rd_ptr];
  assign o_acc_cnt  = acc_cnt;
  assign push       = i_valid && o_ready;
  assign pop        = o_valid && i_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mem[0]  <= '0;
      mem[1]  <= '0;
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      count   <= 2'd0;
      acc_cnt <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= code ^ inj_mask;
        wr_ptr      <= ~wr_ptr;
        acc_cnt     <= acc_cnt + 1'b1;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_hc_enc_pipe.sv
// Directed bench for hc_enc_pipe (DATA_WD=4, CHK_WD=3): table of hand-encoded words plus
// backpressure, async reset, counter wrap and (with HC_ENC_ERR_INJ_EN) injection sequences.
module tb_hc_enc_pipe;

  logic        clk;
  logic        rst_n;
  logic        valid_in;
  logic        ready_out;
  logic [3:0]  data_in;
  logic        valid_out;
  logic        ready_in;
  logic [6:0]  enc_data;
  logic [15:0] acc_cnt;
`ifdef HC_ENC_ERR_INJ_EN
  logic        inj_en;
  logic [2:0]  inj_pos;
`endif

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_acc;

  typedef struct {
    logic [3:0] data;
    logic [6:0] cw;
  } vec_t;
  vec_t vecs[10];

  hc_enc_pipe #(.DATA_WD(4), .CHK_WD(3), .CNT_WD(16)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_valid    (valid_in),
    .o_ready    (ready_out),
    .i_data     (data_in),
    .o_valid    (valid_out),
    .i_ready    (ready_in),
    .o_enc_data (enc_data),
    .o_acc_cnt  (acc_cnt)
`ifdef HC_ENC_ERR_INJ_EN
    ,
    .i_inj_en   (inj_en),
    .i_inj_pos  (inj_pos)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string name, input logic v, input logic [6:0] cw,
                         input logic r, input logic [15:0] acc);
    chk({name, ".valid"}, valid_out, v);
    chk({name, ".data"},  enc_data,  cw);
    chk({name, ".ready"}, ready_out, r);
    chk({name, ".acc"},   acc_cnt,   acc);
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    valid_in = 1'b0;
    ready_in = 1'b0;
    data_in  = 4'h0;
    tick();
    rst_n    = 1'b1;
    exp_acc  = 16'h0;
  endtask

  initial begin
    vecs[0] = '{4'hB, 7'h55};
    vecs[1] = '{4'h0, 7'h00};
    vecs[2] = '{4'hF, 7'h7F};
    vecs[3] = '{4'h1, 7'h07};
    vecs[4] = '{4'h2, 7'h19};
    vecs[5] = '{4'h4, 7'h2A};
    vecs[6] = '{4'h8, 7'h4B};
    vecs[7] = '{4'h6, 7'h33};
    vecs[8] = '{4'h9, 7'h4C};
    vecs[9] = '{4'hC, 7'h61};
`ifdef HC_ENC_ERR_INJ_EN
    inj_en  = 1'b0;
    inj_pos = 3'd0;
`endif

    // Reset state, checked while reset is held
    rst_n    = 1'b0;
    valid_in = 1'b0;
    ready_in = 1'b0;
    data_in  = 4'h0;
    #12;
    chk_out("reset", 1'b0, 7'h00, 1'b1, 16'h0);
    do_reset();

    // Streaming table: one word per cycle, each visible right after its accept edge
    ready_in = 1'b1;
    valid_in = 1'b1;
    foreach (vecs[k]) begin
      data_in = vecs[k].data;
      tick();
      exp_acc = exp_acc + 16'h1;
      chk_out($sformatf("vec%0d", k), 1'b1, vecs[k].cw, 1'b1, exp_acc);
    end
    valid_in = 1'b0;
    tick();
    chk("drain.valid", valid_out, 1'b0);

    // Backpressure: two absorbed, third held off, then in-order drain
    ready_in = 1'b0;
    valid_in = 1'b1;
    data_in  = 4'h1;
    tick();
    exp_acc = exp_acc + 16'h1;
    chk_out("bp1", 1'b1, 7'h07, 1'b1, exp_acc);
    data_in = 4'h2;
    tick();
    exp_acc = exp_acc + 16'h1;
    chk_out("bp2", 1'b1, 7'h07, 1'b0, exp_acc);
    data_in = 4'h4;
    tick();
    chk_out("bp3_stall", 1'b1, 7'h07, 1'b0, exp_acc);
    ready_in = 1'b1;
    tick();
    chk_out("bp4_pop", 1'b1, 7'h19, 1'b1, exp_acc);
    tick();
    exp_acc = exp_acc + 16'h1;
    chk_out("bp5_third", 1'b1, 7'h2A, 1'b1, exp_acc);
    valid_in = 1'b0;
    tick();
    chk("bp6.valid", valid_out, 1'b0);

    // Asynchronous reset with two words buffered
    ready_in = 1'b0;
    valid_in = 1'b1;
    data_in  = 4'hF;
    tick();
    data_in = 4'hB;
    tick();
    chk("prefill.ready", ready_out, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk_out("async_rst", 1'b0, 7'h00, 1'b1, 16'h0);
    tick();
    do_reset();
    tick();
    chk_out("post_rst", 1'b0, 7'h00, 1'b1, 16'h0);

    // Counter wrap
    ready_in = 1'b1;
    valid_in = 1'b1;
    data_in  = 4'h0;
    repeat (65535) tick();
    chk("acc.max", acc_cnt, 16'hFFFF);
    tick();
    chk("acc.wrap", acc_cnt, 16'h0000);
    valid_in = 1'b0;
    tick();

`ifdef HC_ENC_ERR_INJ_EN
    do_reset();
    ready_in = 1'b1;
    valid_in = 1'b1;
    data_in  = 4'hB;
    inj_en   = 1'b1;
    inj_pos  = 3'd3;
    tick();
    chk("inj.pos3", enc_data, 7'h51);
    inj_pos = 3'd0;
    tick();
    chk("inj.pos0", enc_data, 7'h55);
    inj_pos = 3'd7;
    tick();
    chk("inj.pos7", enc_data, 7'h15);
    inj_en = 1'b0;
    tick();
    chk("inj.off", enc_data, 7'h55);
    valid_in = 1'b0;
    tick();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hc_enc_pipe.md
# hc_enc_pipe

Streaming Hamming encoder placed directly upstream of the Hamming decoder stage. Accepts DATA_WD-bit words over a valid/ready handshake, inserts CHK_WD even-parity check bits at power-of-two codeword positions, and presents the (DATA_WD+CHK_WD)-bit codeword through a 2-entry output buffer. Its codeword layout is bit-exact with the decoder's, so a syndrome of zero means no error. An optional error-injection path corrupts one chosen bit per word to exercise the decoder's correction logic.

## Interface
Parameters:
- DATA_WD, 4, payload width.
- CHK_WD, 3, check-bit count; requires DATA_WD+CHK_WD ≤ 2^CHK_WD−1.
- CNT_WD, 16, width of the accepted-word counter.

Ports (N = DATA_WD+CHK_WD):
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_valid  in  1  upstream word valid.
- o_ready  out  1  encoder can accept a word.
- i_data  in  DATA_WD  payload word.
- o_valid  out  1  codeword valid.
- i_ready  in  1  downstream (decoder side) accepts the codeword.
- o_enc_data  out  N  Hamming codeword.
- o_acc_cnt  out  CNT_WD  number of words accepted, wrapping.
- i_inj_en  in  1  (HC_ENC_ERR_INJ_EN only) inject on the next accepted word.
- i_inj_pos  in  CHK_WD  (HC_ENC_ERR_INJ_EN only) 1-based bit position to flip.

## Operation
- Codeword position j (1..N) maps to o_enc_data[j−1].
- Power-of-two positions (1,2,4,…) hold check bits. The remaining positions hold i_data in ascending order, with i_data[0] at the lowest non-power-of-two position.
- Check bit at position 2^i = XOR of every other position j whose index bit i is 1. This gives even parity, so the decoder syndrome is 0.
- Encoding is combinational on i_data. The encoded word is written into the buffer on accept (i_valid && o_ready).
- Buffer:
  - 2-entry FIFO holding encoded words; occupancy count is 0..2.
  - o_ready = (count != 2). o_ready depends on registered state only; there is no combinational path from i_ready.
  - o_valid = (count != 0). o_enc_data always shows the head entry.
  - Pop on o_valid && i_ready.
- Count update:
  - Push only: +1.
  - Pop only: −1.
  - Push and pop in the same cycle: unchanged, data stays in order.
- o_acc_cnt increments on every accept and wraps from 2^CNT_WD−1 to 0.
- Downstream back-pressure: held data and o_valid stay stable until popped.

## Timing
- Reset values: count=0, o_valid=0, o_enc_data=0, o_acc_cnt=0, both buffer entries=0. o_ready=1 during and after reset.
- Reset asserted mid-transfer discards all buffered words immediately (asynchronous). No partial word survives.
- Latency: a word accepted at edge k appears on o_enc_data with o_valid=1 after edge k, provided the buffer was empty.
- Throughput: 1 word/cycle while i_ready=1.
- With i_ready=0: two words are absorbed, then o_ready drops after the edge that fills the buffer.
- Full buffer with i_ready=1: o_ready returns to 1 after the pop edge. No same-cycle push happens at count 2.

## Configuration
- Macro HC_ENC_ERR_INJ_EN.
- Defined:
  - i_inj_en and i_inj_pos exist.
  - On an accept with i_inj_en=1 and 1 ≤ i_inj_pos ≤ N, the stored codeword has bit i_inj_pos−1 inverted.
  - i_inj_pos=0 or >N stores the word unmodified.
  - Injection applies only to the word accepted in that cycle.
- Undefined: both ports are absent and codewords are always clean. Timing is identical in both builds.

## Test plan
All scenarios use DATA_WD=4, CHK_WD=3.
- Reset, then i_data=4'b1011 accepted, i_ready=1 → next cycle o_valid=1, o_enc_data=7'h55, o_acc_cnt=1.
- Back-to-back words 4'h0 and 4'hF with i_ready=1 → codewords 7'h00 then 7'h7F on consecutive cycles.
- i_ready=0 with three words offered → first two accepted, o_ready=0 afterwards. Raising i_ready drains both in order, then the third is accepted.
- Reset asserted with 2 words buffered → o_valid=0, o_enc_data=0, o_acc_cnt=0 immediately.
- o_acc_cnt preloaded near wrap by 65 536 accepts → counter reads 0.
- HC_ENC_ERR_INJ_EN build, 4'b1011 with i_inj_en=1, i_inj_pos=3 → o_enc_data=7'h51. Fed to the decoder, this gives error flag=1 and output 4'b1011.
